// File: rtl/fdd_link_pkg.sv
// Shared register map, bit positions and constants for the FDD host link.
// Used by fdd_host_link and its FIFO; nothing here depends on HOST_LINK_IRQ_EN.
package fdd_link_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } link_reg_e;

  // Z80 status byte bit positions; bits [2:0] hold the saturated RX count
  localparam int STAT_INTRQ   = 7;
  localparam int STAT_RX_NE   = 6;
  localparam int STAT_TX_NF   = 5;
  localparam int STAT_RX_OVF  = 4;
  localparam int STAT_TX_OVF  = 3;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_RX_IE   = 1;
  localparam int CTRL_CLR_OVF = 2;
  localparam int CTRL_TX_IE   = 3;

  localparam int HSTAT_RX_NF  = 7;
  localparam int HSTAT_TX_NE  = 6;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  function automatic logic [2:0] sat_count(input logic [4:0] cnt);
    return (cnt > 5'd7) ? 3'd7 : cnt[2:0];
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Power-of-two circular FIFO with flush; a pop and push in the same cycle are
// both honoured even when full. ovf_set pulses when a push is dropped.
module link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_set
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  // Flush beats both operations; a pop frees the slot a full-FIFO push needs
  assign w_do_pop  = pop & ~empty & ~flush;
  assign w_do_push = push & (~full | w_do_pop) & ~flush;
  assign ovf_set   = push & full & ~w_do_pop & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/fdd_host_link.sv
// FIFO-buffered byte link between the FDD Z80 and the host computer.
// Define HOST_LINK_IRQ_EN to enable rx_ie/tx_ie and the nLINK_INT output.
module fdd_host_link
  import fdd_link_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] BASE_PORT = 8'h20
) (
  input  logic       clk_16mhz,
  input  logic       nRESET,
  input  logic [7:0] addr,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       INTRQ,
  input  logic       ext_a0,
  input  logic       nEXT_RD,
  input  logic       nEXT_WR,
  input  logic [7:0] ext_data_in,
  output logic [7:0] ext_data_out,
  output logic       ext_oe,
  output logic       nLINK_INT
);

  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- Z80 strobe sampling ----------------
  logic       w_z_rd_raw, w_z_wr_raw, w_z_hit_raw;
  logic       r_z_rd, r_z_wr, r_z_rd_d, r_z_wr_d;
  logic       r_z_hit;
  link_reg_e  r_z_reg;
  logic [7:0] r_z_wdata;
  logic       w_z_rd_commit, w_z_wr_commit;

  assign w_z_rd_raw  = ~nIORQ & ~nRD;
  assign w_z_wr_raw  = ~nIORQ & ~nWR;
  assign w_z_hit_raw = (addr[7:2] == BASE_PORT[7:2]);

  // Address and data are latched while the strobe is low, so no hold is needed
  always_ff @(posedge clk_16mhz or negedge nRESET) begin
    if (!nRESET) begin
      r_z_rd    <= 1'b0;
      r_z_wr    <= 1'b0;
      r_z_rd_d  <= 1'b0;
      r_z_wr_d  <= 1'b0;
      r_z_hit   <= 1'b0;
      r_z_reg   <= REG_DATA;
      r_z_wdata <= 8'h00;
    end else begin
      r_z_rd   <= w_z_rd_raw;
      r_z_wr   <= w_z_wr_raw;
      r_z_rd_d <= r_z_rd;
      r_z_wr_d <= r_z_wr;
      if (w_z_rd_raw || w_z_wr_raw) begin
        r_z_hit   <= w_z_hit_raw;
        r_z_reg   <= link_reg_e'(addr[1:0]);
        r_z_wdata <= data_in;
      end
    end
  end

  assign w_z_rd_commit = r_z_rd_d & ~r_z_rd & r_z_hit;
  assign w_z_wr_commit = r_z_wr_d & ~r_z_wr & r_z_hit;

  // ---------------- Host strobe synchronisers ----------------
  logic       r_h_rd1, r_h_rd2, r_h_rd3;
  logic       r_h_wr1, r_h_wr2, r_h_wr3;
  logic [1:0] r_live;
  logic       r_h_rd_arm, r_h_wr_arm;
  logic       r_h_a0;
  logic [7:0] r_h_wdata;
  logic       w_h_rd_commit, w_h_wr_commit;

  // A strobe only counts once it has been seen idle after reset, so one that
  // is still low when reset releases cannot commit on its later rising edge.
  always_ff @(posedge clk_16mhz or negedge nRESET) begin
    if (!nRESET) begin
      r_h_rd1    <= 1'b1;
      r_h_rd2    <= 1'b1;
      r_h_rd3    <= 1'b1;
      r_h_wr1    <= 1'b1;
      r_h_wr2    <= 1'b1;
      r_h_wr3    <= 1'b1;
      r_live     <= 2'b00;
      r_h_rd_arm <= 1'b0;
      r_h_wr_arm <= 1'b0;
      r_h_a0     <= 1'b0;
      r_h_wdata  <= 8'h00;
    end else begin
      r_h_rd1    <= nEXT_RD;
      r_h_rd2    <= r_h_rd1;
      r_h_rd3    <= r_h_rd2;
      r_h_wr1    <= nEXT_WR;
      r_h_wr2    <= r_h_wr1;
      r_h_wr3    <= r_h_wr2;
      r_live     <= {r_live[0], 1'b1};
      r_h_rd_arm <= r_h_rd_arm | (r_live[1] & r_h_rd2);
      r_h_wr_arm <= r_h_wr_arm | (r_live[1] & r_h_wr2);
      if (!r_h_rd1 || !r_h_wr1) r_h_a0 <= ext_a0;
      if (!r_h_wr1) r_h_wdata <= ext_data_in;
    end
  end

  assign w_h_rd_commit = r_h_rd2 & ~r_h_rd3 & r_h_rd_arm;
  assign w_h_wr_commit = r_h_wr2 & ~r_h_wr3 & r_h_wr_arm;

  // ---------------- FIFOs and control ----------------
  logic          w_ctrl_wr, w_flush, w_clr_ovf;
  logic [7:0]    w_rx_rdata, w_tx_rdata;
  logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic [CW-1:0] w_rx_count, w_tx_count;
  logic          w_rx_ovf_set, w_tx_ovf_set;
  logic          r_rx_ovf, r_tx_ovf;
  logic          w_rx_ie, w_tx_ie;

  assign w_ctrl_wr = w_z_wr_commit & (r_z_reg == REG_CTRL);
  assign w_flush   = w_ctrl_wr & r_z_wdata[CTRL_FLUSH];
  assign w_clr_ovf = w_ctrl_wr & r_z_wdata[CTRL_CLR_OVF];

  link_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk_16mhz),
    .rst_n   (nRESET),
    .push    (w_h_wr_commit & ~r_h_a0),
    .pop     (w_z_rd_commit & (r_z_reg == REG_DATA)),
    .flush   (w_flush),
    .wdata   (r_h_wdata),
    .rdata   (w_rx_rdata),
    .empty   (w_rx_empty),
    .full    (w_rx_full),
    .count   (w_rx_count),
    .ovf_set (w_rx_ovf_set)
  );

  link_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk_16mhz),
    .rst_n   (nRESET),
    .push    (w_z_wr_commit & (r_z_reg == REG_DATA)),
    .pop     (w_h_rd_commit & ~r_h_a0),
    .flush   (w_flush),
    .wdata   (r_z_wdata),
    .rdata   (w_tx_rdata),
    .empty   (w_tx_empty),
    .full    (w_tx_full),
    .count   (w_tx_count),
    .ovf_set (w_tx_ovf_set)
  );

  always_ff @(posedge clk_16mhz or negedge nRESET) begin
    if (!nRESET) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      r_rx_ovf <= (r_rx_ovf & ~w_clr_ovf) | w_rx_ovf_set;
      r_tx_ovf <= (r_tx_ovf & ~w_clr_ovf) | w_tx_ovf_set;
    end
  end

`ifdef HOST_LINK_IRQ_EN
  logic r_rx_ie, r_tx_ie;

  always_ff @(posedge clk_16mhz or negedge nRESET) begin
    if (!nRESET) begin
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_rx_ie <= r_z_wdata[CTRL_RX_IE];
      r_tx_ie <= r_z_wdata[CTRL_TX_IE];
    end
  end

  assign w_rx_ie   = r_rx_ie;
  assign w_tx_ie   = r_tx_ie;
  assign nLINK_INT = ~((w_rx_ie & ~w_rx_empty) | (w_tx_ie & w_tx_empty));
`else
  assign w_rx_ie   = 1'b0;
  assign w_tx_ie   = 1'b0;
  assign nLINK_INT = 1'b1;
`endif

  // ---------------- Read-back paths ----------------
  logic [7:0] w_z_stat, w_z_ctrl;
  logic [2:0] w_rx_cnt_sat;

  assign w_rx_cnt_sat = sat_count(5'(w_rx_count));
  assign w_z_stat = {INTRQ, ~w_rx_empty, ~w_tx_full, r_rx_ovf, r_tx_ovf, w_rx_cnt_sat};
  assign w_z_ctrl = {4'h0, w_tx_ie, 1'b0, w_rx_ie, 1'b0};

  always_comb begin
    data_out = EMPTY_READ;
    case (link_reg_e'(addr[1:0]))
      REG_DATA: data_out = w_rx_empty ? EMPTY_READ : w_rx_rdata;
      REG_STAT: data_out = w_z_stat;
      REG_CTRL: data_out = w_z_ctrl;
      REG_RSVD: data_out = EMPTY_READ;
      default:  data_out = EMPTY_READ;
    endcase
  end

  assign data_oe      = w_z_rd_raw & w_z_hit_raw;
  assign ext_data_out = ext_a0 ? {~w_rx_full, ~w_tx_empty, 6'h00}
                               : (w_tx_empty ? EMPTY_READ : w_tx_rdata);
  assign ext_oe       = ~nEXT_RD;

endmodule
